dac_spi_driver: RTL and testbench
=================================

DAC_SPI_DRIVER -- requirements
Module: dac_spi_driver

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning dac_sclk half-period in clk cycles; legal range 2..255.
REQ-002 Parameter CS_GAP, default 2, meaning the minimum number of clk cycles dac_cs_n stays high between frames; legal range 1..255.
REQ-003 Parameter CTRL, default 4'b0000, meaning the 4 DAC control bits sent at the head of every frame.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sample_in  input  8  unsigned waveform sample from the sine generator output.
REQ-007 sample_vld  input  1  one-cycle strobe; sample_in is valid in this cycle.
REQ-008 gain  input  4  unsigned amplitude multiplier; sampled together with sample_in.
REQ-009 dac_cs_n  output  1  DAC chip select, active-low.
REQ-010 dac_sclk  output  1  DAC serial clock; idles low.
REQ-011 dac_din  output  1  DAC serial data, MSB first.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 done  output  1  one-cycle pulse in the cycle dac_cs_n returns high after a frame.
REQ-014 ovf  output  1  one-cycle pulse when a held, unsent sample is overwritten.

Function
REQ-015 On a sample_vld cycle, the block SHALL register product = sample_in * gain (12-bit unsigned, no truncation, max 3825) into a one-entry holding register and set hold_full on the next edge.
REQ-016 If hold_full is already set and the FSM is not consuming it that cycle, a new sample_vld SHALL overwrite the held value (newest wins) and pulse ovf for one cycle.
REQ-017 If sample_vld coincides with the LOAD cycle, the FSM SHALL take the old held value, the new value SHALL be captured with hold_full remaining 1, and ovf SHALL stay 0.
REQ-018 The frame SHALL be 16 bits, {CTRL[3:0], product[11:0]}, shifted out MSB first.
REQ-019 FSM states SHALL be IDLE, LOAD, SHIFT and GAP.
REQ-020 IDLE -> LOAD SHALL occur when hold_full = 1.
REQ-021 LOAD SHALL last exactly one cycle: dac_cs_n = 0, the shift register loaded from the holding register, dac_din = frame bit 15, hold_full cleared unless set again per REQ-017.
REQ-022 In SHIFT, each bit SHALL occupy 2*CLK_DIV clk cycles: dac_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-023 dac_din SHALL change only when dac_sclk falls; the DAC samples on the rising edge of dac_sclk.
REQ-024 SHIFT SHALL last 32*CLK_DIV cycles, so dac_cs_n is low for 1 + 32*CLK_DIV cycles per frame.
REQ-025 SHIFT -> GAP SHALL raise dac_cs_n, force dac_sclk low and pulse done.
REQ-026 GAP SHALL hold dac_cs_n high for CS_GAP cycles, then go to IDLE; a pending sample is launched from IDLE on the next cycle.
REQ-027 Latency: a sample_vld at cycle T with the FSM idle and hold_full = 0 SHALL give dac_cs_n falling at T+2.
REQ-028 dac_sclk, dac_din and dac_cs_n SHALL be driven directly from flops (glitch-free).
REQ-029 sample_vld asserted on consecutive cycles SHALL be treated as separate samples.

Reset
REQ-030 While rst_n = 0, the block SHALL set the FSM to IDLE, hold_full = 0, holding and shift registers = 0, divider = 0, dac_cs_n = 1, dac_sclk = 0, dac_din = 0, busy = 0, done = 0, ovf = 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately and discard the held sample; after release no frame starts until a new sample_vld.

Verification
REQ-032 CLK_DIV = 4: sample_in = 8'hFF, gain = 4'hF, one strobe -> dac_cs_n low 129 cycles, frame 16'h0EF1 received on dac_sclk rising edges, done pulses once.
REQ-033 gain = 0, sample_in = 8'hA5 -> frame 16'h0000; CTRL = 4'b1010 -> frame 16'hA000.
REQ-034 Second strobe (8'h10, then 8'h20, gain = 1) during SHIFT, then a third (8'h30) before the frame ends -> ovf pulses once, second frame carries 12'h030, 8'h20 is never sent.
REQ-035 Strobe exactly in the LOAD cycle -> ovf = 0, back-to-back frames, dac_cs_n high for exactly CS_GAP+1 cycles between them.
REQ-036 rst_n pulsed low at bit 7 of SHIFT -> outputs at reset values in the same cycle, no done pulse, idle until the next strobe.
REQ-037 Continuous strobes every 200 cycles, CLK_DIV = 4 -> every sample sent, ovf never asserted, dac_sclk never toggles while dac_cs_n = 1.

Source files
------------

// File: rtl/dac_spi_driver.sv
// dac_spi_driver
// Takes 8-bit waveform samples, scales them by a 4-bit gain and ships each
// 12-bit product to a serial DAC as a 16-bit frame {CTRL, product}, MSB first.
// A one-entry holding register decouples the sample strobe from the serial
// link. The newest sample always wins, and an overwritten unsent sample is
// flagged on ovf.
module dac_spi_driver #(
  parameter int         CLK_DIV = 4,       // dac_sclk half-period in clk cycles (2..255)
  parameter int         CS_GAP  = 2,       // min clk cycles dac_cs_n stays high between frames (1..255)
  parameter logic [3:0] CTRL    = 4'b0000  // control nibble at the head of every frame
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_vld,
  input  logic [3:0] gain,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  localparam logic [3:0] BIT_LAST = 4'd15;

  logic [1:0]  state_reg;
  logic [11:0] hold_reg;
  logic        hold_full_reg;
  // Holds the 15 frame bits still to be sent. Bit 15 (CTRL[3]) goes straight
  // to dac_din when the frame launches.
  logic [14:0] shift_reg;
  logic [7:0]  div_cnt_reg;
  logic [3:0]  bit_cnt_reg;
  logic [7:0]  gap_cnt_reg;
  logic        cs_n_reg;
  logic        sclk_reg;
  logic        din_reg;
  logic        done_reg;
  logic        ovf_reg;

  logic [11:0] product;
  logic        consuming;

  // The full 12-bit product (at most 255*15 = 3825), so no truncation.
  assign product   = {4'b0000, sample_in} * {8'h00, gain};
  // The LOAD cycle is the cycle in which the FSM takes the held sample.
  assign consuming = (state_reg == LOAD);

  // Holding register: newest sample wins. Overwriting an unsent sample raises ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg      <= 12'd0;
      hold_full_reg <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      ovf_reg <= 1'b0;
      if (sample_vld) begin
        hold_reg      <= product;
        hold_full_reg <= 1'b1;
        // A strobe in the LOAD cycle refills the register that LOAD just
        // emptied, so no sample is lost.
        ovf_reg       <= hold_full_reg && !consuming;
      end else if (consuming) begin
        hold_full_reg <= 1'b0;
      end
    end
  end

  // Frame sequencer. All serial pins come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= 15'd0;
      div_cnt_reg <= 8'd0;
      bit_cnt_reg <= 4'd0;
      gap_cnt_reg <= 8'd0;
      cs_n_reg    <= 1'b1;
      sclk_reg    <= 1'b0;
      din_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (hold_full_reg) begin
            // Present the frame MSB as chip select drops. The MSB is a
            // constant, so it does not depend on the holding register.
            state_reg <= LOAD;
            cs_n_reg  <= 1'b0;
            din_reg   <= CTRL[3];
          end
        end
        LOAD: begin
          shift_reg   <= {CTRL[2:0], hold_reg};
          div_cnt_reg <= 8'd0;
          bit_cnt_reg <= 4'd0;
          state_reg   <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= 8'd0;
            if (!sclk_reg) begin
              sclk_reg <= 1'b1;
            end else if (bit_cnt_reg == BIT_LAST) begin
              // The last falling edge ends the frame.
              state_reg   <= GAP;
              cs_n_reg    <= 1'b1;
              sclk_reg    <= 1'b0;
              din_reg     <= 1'b0;
              done_reg    <= 1'b1;
              gap_cnt_reg <= 8'd0;
            end else begin
              // Falling edge: move on to the next bit while the DAC is not sampling.
              sclk_reg    <= 1'b0;
              din_reg     <= shift_reg[14];
              shift_reg   <= {shift_reg[13:0], 1'b0};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign dac_cs_n = cs_n_reg;
  assign dac_sclk = sclk_reg;
  assign dac_din  = din_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Bench for dac_spi_driver. Two instances share the stimulus (CTRL = 0000 and
// CTRL = 1010). A cycle-timing model predicts every output on every cycle.
// Serial receivers reassemble the frames on dac_sclk rising edges.
module tb_dac_spi_driver;

  localparam int         D     = 4;
  localparam int         G     = 2;
  localparam logic [3:0] CTRL0 = 4'b0000;
  localparam logic [3:0] CTRL1 = 4'b1010;
  localparam int         FLEN  = 32 * D;   // SHIFT length in cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_vld = 1'b0;
  logic [3:0] gain = 4'h0;
  logic [1:0] cs_n, sclk, din, busy, done, ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dac_spi_driver #(.CLK_DIV(D), .CS_GAP(G), .CTRL(CTRL0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_vld(sample_vld), .gain(gain),
    .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]), .dac_din(din[0]),
    .busy(busy[0]), .done(done[0]), .ovf(ovf[0]));

  dac_spi_driver #(.CLK_DIV(D), .CS_GAP(G), .CTRL(CTRL1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_vld(sample_vld), .gain(gain),
    .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]), .dac_din(din[1]),
    .busy(busy[1]), .done(done[1]), .ovf(ovf[1]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] ctrl_of(input int i);
    return (i == 0) ? CTRL0 : CTRL1;
  endfunction

  // ---------------- behavioural timing model ----------------
  // A frame launched with LOAD at cycle L keeps cs_n low over L..L+FLEN.
  // done pulses at L+FLEN+1, busy holds through L+FLEN+G, and the FSM is
  // idle afterwards. An idle FSM that sees a held sample launches LOAD on
  // the next cycle.
  longint     n = 0;
  bit         has_l = 1'b0;
  longint     l_cyc = 0;
  bit         hold_m = 1'b0;
  logic [11:0] held_m = 12'd0;
  bit         ovf_m = 1'b0;
  logic [11:0] cur_pay = 12'd0;
  longint     k;
  bit         in_frame, is_load, idle_now, launch, e_sclk, e_din;
  logic [15:0] fr;
  int         done_cnt = 0, ovf_cnt = 0, low_run = 0, high_run = 0, last_low = 0, last_high = 0;
  logic [11:0] sent_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        check("rst_cs_n", cs_n[i], 1);
        check("rst_sclk", sclk[i], 0);
        check("rst_din",  din[i],  0);
        check("rst_busy", busy[i], 0);
        check("rst_done", done[i], 0);
        check("rst_ovf",  ovf[i],  0);
      end
      has_l = 1'b0; hold_m = 1'b0; ovf_m = 1'b0; low_run = 0; high_run = 0;
    end else begin
      is_load = has_l && (n == l_cyc);
      if (is_load) cur_pay = held_m;
      k = has_l ? (n - l_cyc) : -1000;
      in_frame = has_l && (k >= 0) && (k <= FLEN);
      for (int i = 0; i < 2; i++) begin
        fr = {ctrl_of(i), cur_pay};
        e_sclk = in_frame && (k >= 1) && (((k - 1) % (2 * D)) >= D);
        check("cs_n", cs_n[i], !in_frame);
        check("sclk", sclk[i], e_sclk);
        if (in_frame) begin
          e_din = (k == 0) ? fr[15] : fr[15 - int'((k - 1) / (2 * D))];
          check("din", din[i], e_din);
        end
        check("busy", busy[i], has_l && (k >= 0) && (k <= FLEN + G));
        check("done", done[i], has_l && (k == FLEN + 1));
        check("ovf",  ovf[i],  ovf_m);
      end
      done_cnt += int'(done[0]);
      ovf_cnt  += int'(ovf[0]);
      if (!cs_n[0]) begin
        low_run++;
        if (high_run > 0) last_high = high_run;
        high_run = 0;
      end else begin
        high_run++;
        if (low_run > 0) last_low = low_run;
        low_run = 0;
      end
      // advance the model by one cycle
      idle_now = !has_l || (k > FLEN + G);
      launch   = idle_now && hold_m;
      ovf_m    = sample_vld && hold_m && !is_load;
      if (sample_vld) begin
        held_m = 12'(int'(sample_in) * int'(gain));
        hold_m = 1'b1;
      end else if (is_load) begin
        hold_m = 1'b0;
      end
      if (launch) begin
        l_cyc = n + 1;
        has_l = 1'b1;
      end
    end
    n++;
  end

  // ---------------- serial receivers ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : rx
    logic [15:0] sh = 16'h0000;
    logic [15:0] last_frame = 16'h0000;
    int          cnt = 0;
    int          nframes = 0;
    always @(posedge sclk[gi] or posedge cs_n[gi]) begin
      if (cs_n[gi]) begin
        if (rst_n === 1'b1) begin
          check("rx_bits", cnt, 16);
          check("rx_frame", sh, {ctrl_of(gi), cur_pay});
          last_frame = sh;
          nframes++;
          if (gi == 0) begin
            sent_q.push_back(sh[11:0]);
            $display("[TB] frame received 0x%04h", sh);
          end
        end
        cnt = 0;
      end else begin
        sh = {sh[14:0], din[gi]};
        cnt++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic strobe(input logic [7:0] s, input logic [3:0] g);
    @(posedge clk); #1;
    sample_in = s; gain = g; sample_vld = 1'b1;
    @(posedge clk); #1;
    sample_vld = 1'b0;
  endtask

  int d0, o0, f0, s0;
  logic [11:0] exp_pay[10];

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Full-scale sample: latency, frame content, cs_n low length, single done.
    d0 = done_cnt; f0 = rx[0].nframes;
    strobe(8'hFF, 4'hF);
    check("lat_t1_cs_high", cs_n[0], 1);
    @(posedge clk); #1;
    check("lat_t2_cs_low", cs_n[0], 0);
    repeat (200) @(posedge clk);
    check("fullscale_frame0", rx[0].last_frame, 16'h0EF1);
    check("fullscale_frame1", rx[1].last_frame, 16'hAEF1);
    check("fullscale_cs_low_len", last_low, 129);
    check("fullscale_done_once", done_cnt - d0, 1);
    check("fullscale_nframes", rx[0].nframes - f0, 1);

    // Zero gain gives an all-zero payload.
    strobe(8'hA5, 4'h0);
    repeat (200) @(posedge clk);
    check("gain0_frame0", rx[0].last_frame, 16'h0000);
    check("gain0_frame1", rx[1].last_frame, 16'hA000);

    // Overwrite while held: 0x20 is lost, 0x30 is sent, ovf pulses once.
    o0 = ovf_cnt; s0 = sent_q.size();
    strobe(8'h10, 4'h1);
    repeat (30) @(posedge clk);
    strobe(8'h20, 4'h1);
    repeat (30) @(posedge clk);
    strobe(8'h30, 4'h1);
    repeat (350) @(posedge clk);
    check("ovr_ovf_once", ovf_cnt - o0, 1);
    check("ovr_nframes", sent_q.size() - s0, 2);
    if (sent_q.size() >= s0 + 2) begin
      check("ovr_first_pay", sent_q[s0], 12'h010);
      check("ovr_second_pay", sent_q[s0+1], 12'h030);
    end

    // Strobe in the LOAD cycle: no ovf, back-to-back frames, gap = CS_GAP+1.
    o0 = ovf_cnt; s0 = sent_q.size();
    strobe(8'h11, 4'h1);
    @(posedge clk); #1;
    check("load_cycle_cs_low", cs_n[0], 0);
    sample_in = 8'h22; gain = 4'h1; sample_vld = 1'b1;
    @(posedge clk); #1;
    sample_vld = 1'b0;
    repeat (350) @(posedge clk);
    check("load_ovf_zero", ovf_cnt - o0, 0);
    check("load_gap_len", last_high, G + 1);
    check("load_nframes", sent_q.size() - s0, 2);
    if (sent_q.size() >= s0 + 2) begin
      check("load_first_pay", sent_q[s0], 12'h011);
      check("load_second_pay", sent_q[s0+1], 12'h022);
    end

    // Reset in the middle of bit 7: immediate abort, no done, stays idle.
    d0 = done_cnt; f0 = rx[0].nframes;
    strobe(8'h77, 4'h3);
    repeat (60) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cs_n", cs_n[0], 1);
    check("midrst_sclk", sclk[0], 0);
    check("midrst_din", din[0], 0);
    check("midrst_busy", busy[0], 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (200) @(posedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_frame", rx[0].nframes - f0, 0);
    check("midrst_idle", busy[0], 0);

    // Continuous strobes every 200 cycles: every sample sent, never an ovf.
    o0 = ovf_cnt; s0 = sent_q.size();
    for (int j = 0; j < 10; j++) begin
      logic [7:0] s;
      logic [3:0] g;
      s = 8'($urandom); g = 4'($urandom);
      exp_pay[j] = 12'(int'(s) * int'(g));
      strobe(s, g);
      repeat (198) @(posedge clk);
    end
    repeat (100) @(posedge clk);
    check("stream_ovf_zero", ovf_cnt - o0, 0);
    check("stream_nframes", sent_q.size() - s0, 10);
    for (int j = 0; j < 10; j++)
      if (sent_q.size() > s0 + j) check("stream_pay", sent_q[s0+j], exp_pay[j]);

    // Random traffic: sparse strobes with occasional back-to-back and overwrites.
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      sample_vld = ($urandom_range(0, 39) == 0);
      sample_in  = 8'($urandom);
      gain       = 4'($urandom);
    end
    @(posedge clk); #1 sample_vld = 1'b0;
    repeat (300) @(posedge clk);
    check("final_idle", busy[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
